// File: rtl/apb_sram_slave.sv
// APB4 SRAM slave with configurable width, depth and wait states.
// Supports byte-strobed writes and PSLVERR for out-of-range or misaligned addresses.
module apb_sram_slave #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   input  logic [ADDR_W-1:0]   PADDR,
   input  logic [DATA_W-1:0]   PWDATA,
   input  logic [DATA_W/8-1:0] PSTRB,
   input  logic                PWRITE,
   input  logic                PSEL,
   input  logic                PENABLE,
   output logic                PREADY,
   output logic [DATA_W-1:0]   PRDATA,
   output logic                PSLVERR,
   output logic [1:0]          fsm_state
);
   localparam int NB = DATA_W / 8;
   localparam int AL = $clog2(NB);
   localparam int IW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] AL_MASK = ADDR_W'((64'd1 << AL) - 64'd1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NB-1:0]     strb_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] cur_idx;
   logic              cur_write;
   logic              cur_err;
   logic [IW-1:0]     mem_idx;
   logic              setup;
   logic              enter_resp;

   // With no wait states RESP is entered on the setup edge, before the
   // capture registers hold the request, so decode straight from the bus.
   always_comb begin
      cur_addr   = (state == S_IDLE) ? PADDR : addr_q;
      cur_write  = (state == S_IDLE) ? PWRITE : write_q;
      cur_idx    = cur_addr >> AL;
      cur_err    = (cur_idx >= ADDR_W'(DEPTH)) || ((cur_addr & AL_MASK) != '0);
      mem_idx    = cur_idx[IW-1:0];
      setup      = (state == S_IDLE) && PSEL && !PENABLE;
      enter_resp = (setup && (WAIT_STATES == 0)) ||
                   ((state == S_WAIT) && PSEL && (cnt == 4'd1));
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
      end else begin
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         if (enter_resp) begin
            PREADY  <= 1'b1;
            PSLVERR <= cur_err;
            if (!cur_write) PRDATA <= cur_err ? '0 : mem[mem_idx];
         end
         case (state)
            S_IDLE: begin
               if (setup) begin
                  addr_q  <= PADDR;
                  write_q <= PWRITE;
                  wdata_q <= PWDATA;
                  strb_q  <= PSTRB;
                  cnt     <= 4'(WAIT_STATES);
                  state   <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               if (!PSEL) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) state <= S_RESP;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write commits on the edge leaving RESP; storage itself has no reset.
   always_ff @(posedge PCLK) begin
      if ((state == S_RESP) && write_q && !cur_err) begin
         for (int i = 0; i < NB; i++) begin
            if (strb_q[i]) mem[mem_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
         end
      end
   end

   assign fsm_state = state;

endmodule

// File: doc/apb_sram_slave.md
# apb_sram_slave

Parametrised APB4 memory-mapped SRAM slave: the next-generation register/memory target on the APB side of the AHB-to-APB bridge. It generalises the fixed 256×32 slave with configurable data width, depth and wait states. It adds byte-strobed writes and PSLVERR signalling for out-of-range or misaligned accesses. Access timing is driven by a small FSM, so PREADY is a real handshake rather than tied high.

## Interface
Parameters:
- DATA_W, 32, data bus width; multiple of 8, range 8..64; NB = DATA_W/8 byte lanes, AL = log2(NB) alignment bits
- ADDR_W, 32, PADDR width
- DEPTH, 256, number of DATA_W-bit words; power of two, ≥2
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase; range 0..15

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- PCLK  in  1  clock; all state updates on its rising edge
- PRESETn  in  1  asynchronous, active-low reset
- PADDR  in  ADDR_W  byte address
- PWDATA  in  DATA_W  write data
- PSTRB  in  NB  write byte strobes; ignored on reads
- PWRITE  in  1  1 = write, 0 = read
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PREADY  out  1  transfer completes this cycle
- PRDATA  out  DATA_W  read data; valid when PREADY=1 on a read
- PSLVERR  out  1  error response; valid when PREADY=1

## Operation
- Word index = PADDR >> AL.
- Error condition ERR = (index ≥ DEPTH) or (PADDR[AL-1:0] ≠ 0).
- FSM states:
  - IDLE: PREADY=0. Setup phase (PSEL=1, PENABLE=0) captures address, PWRITE, PWDATA and PSTRB, loads cnt=WAIT_STATES, and goes to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: PREADY=0. Each cycle with PSEL=1 decrements cnt; at cnt==1 goes to RESP. PSEL=0 (master abort) returns to IDLE with no memory effect.
  - RESP: PREADY=1 for exactly one cycle, then unconditionally IDLE.
- Read: the memory word (or 0 if ERR) is loaded into PRDATA on the edge entering RESP. PSLVERR=ERR is loaded on the same edge. PRDATA holds its value until the next read RESP; writes do not change it.
- Write: committed on the edge ending RESP, only if ERR=0. Byte lane i is updated only where PSTRB[i]=1. PSTRB=0 writes nothing and raises no error.
- On error, memory is untouched, PSLVERR=1 and read data is 0.
- PSLVERR is 0 in every non-RESP cycle.
- Memory contents are not reset.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, FSM=IDLE, cnt=0.
- Access latency, setup edge to completion: setup cycle, then WAIT_STATES cycles with PREADY=0, then 1 RESP cycle. Total is 2+WAIT_STATES cycles per transfer.
- Back-to-back transfers: a setup phase in the cycle immediately after RESP is accepted from IDLE, with no dead cycle.
- Read-after-write to the same address on consecutive transfers returns the new data.
- Reset asserted mid-transfer (WAIT or RESP): outputs return to reset values asynchronously and the pending write is dropped. The word keeps its old value.
- Address and control are sampled only at setup. Changes during the access phase are ignored, per APB rules.

## Test plan
- DATA_W=32, WAIT_STATES=0: write 0xDEADBEEF to 0x10, PSTRB=0xF, then read 0x10. Each transfer takes 2 cycles, PREADY=1 in cycle 2, the read returns 0xDEADBEEF, PSLVERR=0.
- WAIT_STATES=3: read 0x04. PREADY is 0 for 3 access cycles, then 1 for one cycle with the data. A total of 5 cycles is required.
- Byte strobes: write 0x11223344 to 0x20 with PSTRB=0xF, then 0xAABBCCDD with PSTRB=0x5. The read returns 0x11BB33DD.
- Error cases:
  - DEPTH=256, write to 0x400: PSLVERR=1 with PREADY, memory unchanged.
  - Read of 0x402: PSLVERR=1, PRDATA=0.
- Reset mid-access: WAIT_STATES=2, write 0xCAFEF00D to 0x08, deassert PRESETn during the WAIT state. PREADY, PSLVERR and PRDATA go to 0 immediately. After release, a read of 0x08 returns the prior value.
- Back-to-back: write 0x1 to 0x0 and read 0x0 with no idle cycle between, plus PSEL dropped mid-WAIT on a write to 0x4. The read returns 0x1, and the aborted write leaves 0x4 unchanged.
